// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and parity helper
// for the parity-capable UART transmitter.
package uart_pkg;

  localparam int CLKS_PER_BIT = 14;
  localparam int DATA_BITS    = 8;
  localparam int FRAME_BITS   = 11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Even parity makes the total ones count even, odd makes it odd.
  function automatic logic parity_calc(
    input logic [DATA_BITS-1:0] d,
    input logic                 odd
  );
    return odd ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_tx_parity.sv
// 8-bit UART transmitter: start, 8 data bits MSB first,
// parity bit, stop bit; one-cycle done pulse per frame.
module uart_tx_parity
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
  input  logic       clk_3125,
  input  logic       rst,
  input  logic       parity_type,
  input  logic       tx_start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  state_t        r_state = IDLE;
  logic [CW-1:0] r_cnt   = '0;
  logic [2:0]    r_idx   = '0;
  logic [7:0]    r_shift = '0;
  logic          r_par   = 1'b0;
  logic          r_tx    = 1'b1;
  logic          r_done  = 1'b0;

  logic w_last;

  assign w_last  = (r_cnt == LAST);
  assign tx      = r_tx;
  assign tx_done = r_done;

  always_ff @(posedge clk_3125 or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
          if (tx_start) begin
            r_shift <= data;
            r_par   <= parity_calc(data, parity_type);
            r_tx    <= 1'b0;
            r_state <= START;
          end else begin
            r_tx <= 1'b1;
          end
        end
        START: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_idx   <= 3'd7;
            r_tx    <= r_shift[7];
            r_state <= DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_last) begin
            r_cnt <= '0;
            if (r_idx == 3'd0) begin
              r_tx    <= r_par;
              r_state <= PARITY;
            end else begin
              r_idx   <= r_idx - 1'b1;
              r_shift <= {r_shift[6:0], 1'b0};
              r_tx    <= r_shift[6];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_tx    <= 1'b1;
            r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (w_last) begin
            r_cnt  <= '0;
            r_done <= 1'b1;
            // A request on the closing edge starts the next frame at once.
            if (tx_start) begin
              r_shift <= data;
              r_par   <= parity_calc(data, parity_type);
              r_tx    <= 1'b0;
              r_state <= START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_tx    <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_parity.sv
// Directed bench for uart_tx_parity: frame bits on both
// clock phases, done pulse, back-to-back, abort by reset.
module tb_uart_tx_parity;

  logic       clk_3125 = 1'b0;
  logic       rst = 1'b0;
  logic       parity_type = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx;
  logic       tx_done;

  int checks = 0;
  int failures = 0;

  localparam logic [7:0] BD [10] = '{8'h00, 8'hFF, 8'h80, 8'h01, 8'h3C,
                                     8'h7F, 8'h55, 8'hC3, 8'h0F, 8'h96};
  localparam logic BP [10] = '{0, 0, 0, 0, 1, 1, 0, 1, 0, 1};
  localparam logic BE [10] = '{0, 0, 1, 1, 1, 0, 0, 1, 0, 1};

  uart_tx_parity dut (
    .clk_3125    (clk_3125),
    .rst         (rst),
    .parity_type (parity_type),
    .tx_start    (tx_start),
    .data        (data),
    .tx          (tx),
    .tx_done     (tx_done)
  );

  always #5 clk_3125 = ~clk_3125;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input logic p,
                                   input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[8-k];
    if (k == 9) return p;
    return 1'b1;
  endfunction

  task automatic idle(input int n, input string tag);
    repeat (n) begin
      @(negedge clk_3125);
      chk({tag, " idle tx"}, tx, 1'b1);
      chk({tag, " idle done"}, tx_done, 1'b0);
    end
  endtask

  // Entered just after a negedge; returns after the negedge of E0+154.
  task automatic run_frame(input logic [7:0] d, input logic pt,
                           input logic ep, input bit glitch,
                           input string tag);
    logic e;
    data = d;
    parity_type = pt;
    tx_start = 1'b1;
    @(posedge clk_3125);
    #1;
    chk({tag, " E0 tx"}, tx, 1'b0);
    @(negedge clk_3125);
    tx_start = 1'b0;
    data = ~d;
    parity_type = ~pt;
    chk({tag, " m0 tx"}, tx, 1'b0);
    chk({tag, " m0 done"}, tx_done, 1'b0);
    for (int m = 1; m <= 154; m++) begin
      e = (m < 154) ? exp_bit(d, ep, m / 14) : 1'b1;
      @(posedge clk_3125);
      #1;
      chk($sformatf("%s m%0d pos tx", tag, m), tx, e);
      chk($sformatf("%s m%0d pos done", tag, m), tx_done, m == 154);
      @(negedge clk_3125);
      chk($sformatf("%s m%0d neg tx", tag, m), tx, e);
      chk($sformatf("%s m%0d neg done", tag, m), tx_done, m == 154);
      if (glitch && m == 39) begin
        tx_start = 1'b1;
        data = 8'h3C;
      end else begin
        tx_start = 1'b0;
      end
    end
  endtask

  initial begin
    #1;
    chk("powerup tx", tx, 1'b1);
    chk("powerup done", tx_done, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("reset tx", tx, 1'b1);
    chk("reset done", tx_done, 1'b0);
    @(negedge clk_3125);
    rst = 1'b0;
    idle(50, "start");

    run_frame(8'hA5, 1'b0, 1'b0, 1'b0, "a5even");
    idle(3, "a5even");
    run_frame(8'hA5, 1'b1, 1'b1, 1'b0, "a5odd");
    idle(3, "a5odd");

    for (int i = 0; i < 10; i++)
      run_frame(BD[i], BP[i], BE[i], 1'b0, $sformatf("b2b%0d", i));
    idle(3, "b2b");

    run_frame(8'h81, 1'b0, 1'b0, 1'b1, "glitch");
    idle(3, "glitch");

    data = 8'hC3;
    parity_type = 1'b0;
    tx_start = 1'b1;
    @(posedge clk_3125);
    #1;
    chk("abort E0 tx", tx, 1'b0);
    @(negedge clk_3125);
    tx_start = 1'b0;
    repeat (70) @(posedge clk_3125);
    #1;
    chk("abort pre tx", tx, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("abort rst tx", tx, 1'b1);
    chk("abort rst done", tx_done, 1'b0);
    @(negedge clk_3125);
    rst = 1'b0;
    idle(200, "abort");

    run_frame(8'h5A, 1'b1, 1'b1, 1'b0, "after");
    idle(5, "after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
